matrix_transposer: RTL and testbench
====================================

MATRIX_TRANSPOSER -- requirements
Module: matrix_transposer

Interface
REQ-001 SHALL have parameter SZI, default 4: rows per tile, which is also the element count of each output vector.
REQ-002 SHALL have parameter SZJ, default 4: columns per tile, which is also the element count of each input vector.
REQ-003 SHALL have parameter WIDTH, default 8: bits per element.
REQ-004 SHALL have parameter NBANKS, default 2: tile buffers in the ring; legal range 2..4.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous reset, active-high (asserted when 1), despite the name.
REQ-007 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): input row handshake.
REQ-008 SHALL have port in_vec, input, SZJ*WIDTH bits: one tile row; element J occupies bits [J*WIDTH +: WIDTH].
REQ-009 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): output column handshake.
REQ-010 SHALL have port out_vec, output, SZI*WIDTH bits: one tile column; element I occupies bits [I*WIDTH +: WIDTH].
REQ-011 SHALL have port out_last, output, 1 bit: high while out_vec holds column SZJ-1.
REQ-012 SHALL have port flush, input, 1 bit, present only when MATRIX_TRANSPOSER_FLUSH_EN is defined.

Function
REQ-013 SHALL transfer a beat only when valid and ready are both high on a clock edge; valid SHALL NOT depend on ready.
REQ-014 SHALL store accepted row r of the tile into row r of bank wr_bank; r counts 0..SZI-1 and wraps to 0.
REQ-015 SHALL drive in_ready = NOT full[wr_bank], with no combinational path from out_ready.
REQ-016 SHALL, on acceptance of row SZI-1, set full[wr_bank], advance wr_bank modulo NBANKS, and clear r.
REQ-017 SHALL drive out_valid = full[rd_bank]; for column c (0..SZJ-1), out_vec element I SHALL equal element c of stored row I.
REQ-018 SHALL, on acceptance of column SZJ-1, clear full[rd_bank], advance rd_bank modulo NBANKS, and clear c.
REQ-019 SHALL assert out_valid on the cycle after the edge that accepted the tile's last row; this is a latency of 1.
REQ-020 SHALL sustain one row in and one column out per cycle with no bubbles when NBANKS>=2 and no backpressure is applied.
REQ-021 SHALL hold out_vec and out_last stable while out_valid is high and out_ready is low.
REQ-022 SHALL, with all banks full, deassert in_ready until a full bank is released; the release SHALL make in_ready high on the next cycle.
REQ-023 SHALL, with all banks empty, hold out_valid low; a row accepted and a column accepted on the same edge SHALL each update their own bank independently.

Reset
REQ-024 SHALL, while resetn is high, asynchronously clear r, c, wr_bank, rd_bank and all full flags, giving in_ready=1, out_valid=0, out_last=0 and out_vec=0.
REQ-025 SHALL, when reset is asserted mid-tile, discard any partially written or partially read tile; bank storage contents need not be cleared.

Configuration
REQ-026 SHALL, when MATRIX_TRANSPOSER_FLUSH_EN is defined, treat flush=1 with r>0 as closing the tile: rows r..SZI-1 read as zero, and full is set and the bank advanced as in REQ-016.
REQ-027 SHALL, when a row is accepted and flush is asserted on the same edge, include that row in the tile before closing it; flush with r=0 and no row accepted SHALL be a no-op.
REQ-028 SHALL, without MATRIX_TRANSPOSER_FLUSH_EN, omit the flush port and its logic, so that only complete SZI-row tiles are emitted.

Verification (SZI=2, SZJ=3, WIDTH=8, NBANKS=2)
REQ-029 SHALL check: rows {1,2,3} then {4,5,6} with out_ready=1 -> columns {1,4},{2,5},{3,6}, out_last only on {3,6}, and first out_valid one cycle after row 2.
REQ-030 SHALL check: 3 tiles streamed with out_ready held 0 -> in_ready drops after 4 rows; raising out_ready drains tiles in order with no loss.
REQ-031 SHALL check: out_ready toggled 1,0,1,0 during a drain -> out_vec is held during stalls and each column is emitted exactly once.
REQ-032 SHALL check: resetn pulsed high after 1 row or after 1 column -> all outputs are at reset values, and the next tile {7,8,9},{10,11,12} emits {7,10},{8,11},{9,12}.
REQ-033 SHALL check, with the macro defined: row {1,2,3} accepted with flush=1 -> columns {1,0},{2,0},{3,0}.
REQ-034 SHALL check: continuous input and output for 4 tiles -> 12 rows accepted in 12 consecutive cycles and zero idle output cycles after the first.

Source files
------------

// File: rtl/matrix_transposer.sv
// Streaming tile transposer: SZI rows of SZJ elements in, SZJ columns of SZI elements out,
// through a ring of NBANKS tile buffers. Optional flush port under MATRIX_TRANSPOSER_FLUSH_EN.
module matrix_transposer #(
    parameter int unsigned SZI    = 4,
    parameter int unsigned SZJ    = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NBANKS = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SZJ*WIDTH-1:0]   in_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SZI*WIDTH-1:0]   out_vec,
`ifdef MATRIX_TRANSPOSER_FLUSH_EN
    input  logic                   flush,
`endif
    output logic                   out_last
);

    localparam int unsigned RowW  = (SZI > 1) ? $clog2(SZI) : 1;
    localparam int unsigned ColW  = (SZJ > 1) ? $clog2(SZJ) : 1;
    localparam int unsigned BankW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

    typedef logic [RowW-1:0]  row_t;
    typedef logic [ColW-1:0]  col_t;
    typedef logic [BankW-1:0] bank_t;

    localparam row_t  RowLast  = row_t'(SZI - 1);
    localparam col_t  ColLast  = col_t'(SZJ - 1);
    localparam bank_t BankLast = bank_t'(NBANKS - 1);

    row_t              r_q, r_d;
    col_t              c_q, c_d;
    bank_t             wr_q, wr_d;
    bank_t             rd_q, rd_d;
    logic [NBANKS-1:0] full_q, full_d;

    // Tile storage; each row keeps element J at packed index J, matching in_vec.
    logic [SZJ-1:0][WIDTH-1:0] mem_q [NBANKS][SZI];

    logic row_acc;
    logic col_acc;
    logic flush_close;
    logic tile_close;

    function automatic bank_t bank_inc(input bank_t b);
        return (b == BankLast) ? '0 : bank_t'(b + 1'b1);
    endfunction

    assign in_ready  = ~full_q[wr_q];
    assign out_valid = full_q[rd_q];
    assign out_last  = out_valid && (c_q == ColLast);

    assign row_acc = in_valid & in_ready;
    assign col_acc = out_valid & out_ready;

`ifdef MATRIX_TRANSPOSER_FLUSH_EN
    // A flush only closes a tile that holds at least one row, counting one arriving now.
    assign flush_close = flush && in_ready && ((r_q != '0) || row_acc);
`else
    assign flush_close = 1'b0;
`endif

    assign tile_close = (row_acc && (r_q == RowLast)) || flush_close;

    always_comb begin
        r_d    = r_q;
        c_d    = c_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        full_d = full_q;

        if (row_acc) begin
            r_d = row_t'(r_q + 1'b1);
        end
        if (tile_close) begin
            r_d          = '0;
            full_d[wr_q] = 1'b1;
            wr_d         = bank_inc(wr_q);
        end

        if (col_acc) begin
            if (c_q == ColLast) begin
                c_d          = '0;
                full_d[rd_q] = 1'b0;
                rd_d         = bank_inc(rd_q);
            end else begin
                c_d = col_t'(c_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_q    <= '0;
            c_q    <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            full_q <= '0;
        end else begin
            r_q    <= r_d;
            c_q    <= c_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (row_acc) begin
            mem_q[wr_q][r_q] <= in_vec;
        end
`ifdef MATRIX_TRANSPOSER_FLUSH_EN
        // Rows never written in a flushed tile must read back as zero.
        if (flush_close) begin
            for (int i = 0; i < int'(SZI); i++) begin
                if (i >= (int'(r_q) + (row_acc ? 1 : 0))) begin
                    mem_q[wr_q][i] <= '0;
                end
            end
        end
`endif
    end

    always_comb begin
        out_vec = '0;
        for (int i = 0; i < int'(SZI); i++) begin
            if (out_valid) begin
                out_vec[i*WIDTH +: WIDTH] = mem_q[rd_q][i][c_q];
            end
        end
    end

endmodule

// File: tb/tb_matrix_transposer.sv
// Self-checking bench for matrix_transposer: queue-based column model plus directed vectors,
// and a second square instance for the sustained-throughput case.
module tb_matrix_transposer;

    localparam int SZI    = 2;
    localparam int SZJ    = 3;
    localparam int WIDTH  = 8;
    localparam int NBANKS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 resetn;
    logic                 in_valid, in_ready, out_valid, out_ready, out_last, flush;
    logic [SZJ*WIDTH-1:0] in_vec;
    logic [SZI*WIDTH-1:0] out_vec;

    logic        q_in_valid, q_in_ready, q_out_valid, q_out_ready, q_out_last, q_flush;
    logic [23:0] q_in_vec, q_out_vec;

    int n_vec    = 0;
    int n_fail   = 0;
    int cols_out = 0;

    matrix_transposer #(.SZI(SZI), .SZJ(SZJ), .WIDTH(WIDTH), .NBANKS(NBANKS)) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
`ifdef MATRIX_TRANSPOSER_FLUSH_EN
        .flush     (flush),
`endif
        .out_last  (out_last)
    );

    matrix_transposer #(.SZI(3), .SZJ(3), .WIDTH(8), .NBANKS(2)) u_dut_sq (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (q_in_valid),
        .in_ready  (q_in_ready),
        .in_vec    (q_in_vec),
        .out_valid (q_out_valid),
        .out_ready (q_out_ready),
        .out_vec   (q_out_vec),
`ifdef MATRIX_TRANSPOSER_FLUSH_EN
        .flush     (q_flush),
`endif
        .out_last  (q_out_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mkrow(input int a);
        return {8'(3*a + 35), 8'(3*a + 34), 8'(3*a + 33)};
    endfunction

    // Square instance data: tile t, row r, element j holds t*16 + r*4 + j + 1.
    function automatic logic [23:0] qrow(input int k);
        logic [23:0] v;
        for (int j = 0; j < 3; j++) v[j*8 +: 8] = 8'((k/3)*16 + (k%3)*4 + j + 1);
        return v;
    endfunction

    function automatic logic [23:0] qcol(input int n);
        logic [23:0] v;
        for (int i = 0; i < 3; i++) v[i*8 +: 8] = 8'((n/3)*16 + i*4 + (n%3) + 1);
        return v;
    endfunction

    // Model: completed tiles become SZJ expected columns; a bank is busy until its last column leaves.
    logic [SZI*WIDTH-1:0] exp_col[$];
    logic                 exp_last[$];
    logic [SZJ*WIDTH-1:0] rows_buf[SZI];
    int                   rcnt = 0;
    int                   m_tiles;

    always @(negedge clk) begin
        if (resetn) begin
            exp_col.delete();
            exp_last.delete();
            rcnt = 0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_vec", out_vec, 0);
        end else begin
            m_tiles = (exp_col.size() + SZJ - 1) / SZJ;
            chk("out_valid", out_valid, exp_col.size() > 0);
            chk("in_ready", in_ready, m_tiles < NBANKS);
            if (out_valid && exp_col.size() > 0) begin
                chk("out_vec", out_vec, exp_col[0]);
                chk("out_last", out_last, exp_last[0]);
            end
            if (out_valid && out_ready && exp_col.size() > 0) begin
                void'(exp_col.pop_front());
                void'(exp_last.pop_front());
                cols_out++;
            end
            if (in_valid && in_ready) begin
                rows_buf[rcnt] = in_vec;
                rcnt++;
            end
            if (flush && in_ready && rcnt > 0) begin
                for (int i = rcnt; i < SZI; i++) rows_buf[i] = '0;
                rcnt = SZI;
            end
            if (rcnt == SZI) begin
                for (int c = 0; c < SZJ; c++) begin
                    logic [SZI*WIDTH-1:0] col;
                    for (int i = 0; i < SZI; i++) col[i*WIDTH +: WIDTH] = rows_buf[i][c*WIDTH +: WIDTH];
                    exp_col.push_back(col);
                    exp_last.push_back(c == SZJ - 1);
                end
                rcnt = 0;
            end
        end
    end

    // Two-row tile with out_ready high from an empty state; checks latency and each column.
    task automatic run_tile(input logic [23:0] r0, input logic [23:0] r1,
                            input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
        in_valid = 1'b1;
        in_vec   = r0;
        tick();
        in_vec = r1;
        chk("lat_pre_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("lat_valid", out_valid, 1);
        chk("col0", out_vec, c0);
        chk("last0", out_last, 0);
        tick();
        chk("col1", out_vec, c1);
        chk("last1", out_last, 0);
        tick();
        chk("col2", out_vec, c2);
        chk("last2", out_last, 1);
        tick();
        chk("drained", out_valid, 0);
    endtask

    task automatic rst_literals();
        chk("pulse_in_ready", in_ready, 1);
        chk("pulse_out_valid", out_valid, 0);
        chk("pulse_out_last", out_last, 0);
        chk("pulse_out_vec", out_vec, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int base;
        int oc;
        int first_k;
        resetn      = 1'b1;
        in_valid    = 1'b0;
        in_vec      = '0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        q_in_valid  = 1'b0;
        q_in_vec    = '0;
        q_out_ready = 1'b0;
        q_flush     = 1'b0;
        repeat (2) tick();
        resetn = 1'b0;
        tick();

        // Basic transpose with one-cycle latency.
        out_ready = 1'b1;
        run_tile(24'h030201, 24'h060504, 16'h0401, 16'h0502, 16'h0603);

        // Three tiles with no drain: ring fills after four rows, then drains in order.
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_vec = mkrow(acc);
            if (in_ready) acc++;
            tick();
        end
        chk("acc_at_full", acc, 4);
        chk("in_ready_full", in_ready, 0);
        base      = cols_out;
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            in_valid = (acc < 6);
            in_vec   = mkrow(acc);
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("acc_total", acc, 6);
        chk("drain_cols", cols_out - base, 9);

        // Stalled drain: out_ready alternates, every column leaves exactly once.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = mkrow(10);
        tick();
        in_vec = mkrow(11);
        tick();
        in_valid = 1'b0;
        base     = cols_out;
        for (int k = 0; k < 12; k++) begin
            out_ready = (k % 2 == 0);
            tick();
        end
        chk("toggle_cols", cols_out - base, 3);
        chk("toggle_done", out_valid, 0);

        // Reset after one row.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 24'h030201;
        tick();
        resetn   = 1'b1;
        in_valid = 1'b0;
        #1;
        rst_literals();
        tick();
        resetn = 1'b0;
        tick();
        run_tile(24'h090807, 24'h0c0b0a, 16'h0a07, 16'h0b08, 16'h0c09);

        // Reset after one column.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = mkrow(20);
        tick();
        in_vec = mkrow(21);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        resetn    = 1'b1;
        #1;
        rst_literals();
        tick();
        resetn    = 1'b0;
        out_ready = 1'b1;
        tick();
        run_tile(24'h090807, 24'h0c0b0a, 16'h0a07, 16'h0b08, 16'h0c09);

`ifdef MATRIX_TRANSPOSER_FLUSH_EN
        // Flush with the first row closes the tile, missing rows read as zero.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_vec   = 24'h030201;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 1);
        chk("fl_col0", out_vec, 16'h0001);
        tick();
        chk("fl_col1", out_vec, 16'h0002);
        tick();
        chk("fl_col2", out_vec, 16'h0003);
        chk("fl_last", out_last, 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_noop_valid", out_valid, 0);
        chk("fl_noop_ready", in_ready, 1);
        run_tile(24'h030201, 24'h060504, 16'h0401, 16'h0502, 16'h0603);
`endif

        // Square instance: four back-to-back tiles with no bubbles on either side.
        q_out_ready = 1'b1;
        oc          = 0;
        first_k     = -1;
        for (int k = 0; k < 20; k++) begin
            q_in_valid = (k < 12);
            q_in_vec   = qrow(k);
            @(negedge clk);
            if (k < 12) chk("q_in_ready", q_in_ready, 1);
            if (oc > 0 && oc < 12) chk("q_no_bubble", q_out_valid, 1);
            if (q_out_valid && oc < 12) begin
                if (first_k < 0) first_k = k;
                chk("q_col", q_out_vec, qcol(oc));
                chk("q_last", q_out_last, (oc % 3) == 2);
                oc++;
            end
            @(posedge clk);
            #1;
        end
        q_in_valid = 1'b0;
        chk("q_cols", oc, 12);
        chk("q_first_valid", first_k, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
